// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Brief    : Clocked general-purpose register file with two combinational
//            read ports, one synchronous write port, a hard-wired zero
//            register and a valid/ready dump channel that streams every
//            register to the debug unit.
// Options  : REG_BYPASS_EN - when defined, a same-cycle write is forwarded
//            to matching read ports and to the dump snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module register_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rs_sel,
  input  logic [ADDR_W-1:0] i_rt_sel,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_rd_sel,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_dump_start,
  input  logic              i_dump_ready,
  output logic              o_dump_valid,
  output logic [DATA_W-1:0] o_dump_data,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic              o_dump_busy,
  output logic              o_dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] file_view [DEPTH];
  logic              fwd_rs;
  logic              fwd_rt;
  logic              fwd_load;
  logic [DATA_W-1:0] load_word;

  // Register 0 has no storage; its view is a constant zero.
  assign file_view[0] = '0;

  // Physical registers 1..DEPTH-1, each with its own write decode.
  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    logic [DATA_W-1:0] word;

    // Capture write-back data addressed to this register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        word <= '0;
      end else if (i_wr_en && (i_rd_sel == ADDR_W'(g))) begin
        word <= i_wr_data;
      end
    end

    assign file_view[g] = word;
  end

  // Forwarding matches: a same-cycle write to a non-zero register
  // overrides the stored value only when the bypass option is built in.
`ifdef REG_BYPASS_EN
  assign fwd_rs   = i_wr_en && (i_rd_sel != '0) && (i_rd_sel == i_rs_sel);
  assign fwd_rt   = i_wr_en && (i_rd_sel != '0) && (i_rd_sel == i_rt_sel);
  assign fwd_load = i_wr_en && (i_rd_sel != '0) && (i_rd_sel == index);
`else
  assign fwd_rs   = 1'b0;
  assign fwd_rt   = 1'b0;
  assign fwd_load = 1'b0;
`endif

  assign o_rs_data = fwd_rs   ? i_wr_data : file_view[i_rs_sel];
  assign o_rt_data = fwd_rt   ? i_wr_data : file_view[i_rt_sel];
  assign load_word = fwd_load ? i_wr_data : file_view[index];

  // Dump sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dump next-state decode and handshake/status outputs.
  always_comb begin
    state_nxt    = state;
    o_dump_valid = 1'b0;
    o_dump_busy  = 1'b0;
    o_dump_done  = 1'b0;
    case (state)
      IDLE: begin
        if (i_dump_start) state_nxt = LOAD;
      end
      LOAD: begin
        o_dump_busy = 1'b1;
        state_nxt   = SEND;
      end
      SEND: begin
        o_dump_busy  = 1'b1;
        o_dump_valid = 1'b1;
        if (i_dump_ready) state_nxt = (index == LAST_IDX) ? DONE : LOAD;
      end
      DONE: begin
        o_dump_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Dump index walk and word snapshot; the word is frozen once loaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      index       <= '0;
      o_dump_data <= '0;
      o_dump_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_dump_start) index <= '0;
        end
        LOAD: begin
          o_dump_data <= load_word;
          o_dump_addr <= index;
        end
        SEND: begin
          if (i_dump_ready && (index != LAST_IDX)) index <= index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_bank
// Brief    : Directed self-checking bench for register_bank: reset, write and
//            read, forwarding, full dump timing, backpressure and reset abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [ADDR_W-1:0] i_rs_sel;
  logic [ADDR_W-1:0] i_rt_sel;
  logic [DATA_W-1:0] o_rs_data;
  logic [DATA_W-1:0] o_rt_data;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_rd_sel;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_dump_start;
  logic              i_dump_ready;
  logic              o_dump_valid;
  logic [DATA_W-1:0] o_dump_data;
  logic [ADDR_W-1:0] o_dump_addr;
  logic              o_dump_busy;
  logic              o_dump_done;

  int checks   = 0;
  int failures = 0;

  register_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rs_sel     (i_rs_sel),
    .i_rt_sel     (i_rt_sel),
    .o_rs_data    (o_rs_data),
    .o_rt_data    (o_rt_data),
    .i_wr_en      (i_wr_en),
    .i_rd_sel     (i_rd_sel),
    .i_wr_data    (i_wr_data),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_data  (o_dump_data),
    .o_dump_addr  (o_dump_addr),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] sel, input logic [DATA_W-1:0] d);
    i_wr_en   = 1'b1;
    i_rd_sel  = sel;
    i_wr_data = d;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic wait_for_word(input logic [ADDR_W-1:0] idx, output bit found);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (o_dump_valid && (o_dump_addr == idx)) begin
        found = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_for_done(output bit found);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (o_dump_done) begin
        found = 1'b1;
        return;
      end
      tick();
    end
  endtask

  initial begin
    bit found;
    int words;
    int first_valid;
    int done_cnt;
    int done_cycle;
    int stray;

    i_rst_n      = 1'b0;
    i_rs_sel     = '0;
    i_rt_sel     = '0;
    i_wr_en      = 1'b0;
    i_rd_sel     = '0;
    i_wr_data    = '0;
    i_dump_start = 1'b0;
    i_dump_ready = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    // Reset clears contents written before it
    write_reg(5'd5, 32'hDEADBEEF);
    i_rs_sel = 5'd5;
    #1;
    check_value("pre_reset_rd5", o_rs_data, 32'hDEADBEEF);
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    #1;
    check_value("reset_rd5", o_rs_data, 32'h0);
    check_value("reset_valid", {31'b0, o_dump_valid}, 32'h0);
    check_value("reset_busy", {31'b0, o_dump_busy}, 32'h0);
    check_value("reset_done", {31'b0, o_dump_done}, 32'h0);
    check_value("reset_ddata", o_dump_data, 32'h0);
    check_value("reset_daddr", {27'b0, o_dump_addr}, 32'h0);

    // Write then read on both ports; register 0 stays zero
    write_reg(5'd7, 32'h12345678);
    i_rs_sel = 5'd7;
    i_rt_sel = 5'd7;
    #1;
    check_value("rd_rs7", o_rs_data, 32'h12345678);
    check_value("rd_rt7", o_rt_data, 32'h12345678);
    write_reg(5'd0, 32'hFFFFFFFF);
    i_rs_sel = 5'd0;
    i_rt_sel = 5'd0;
    #1;
    check_value("rd_rs0", o_rs_data, 32'h0);
    check_value("rd_rt0", o_rt_data, 32'h0);

    // Same-cycle write visibility
    i_wr_en   = 1'b1;
    i_rd_sel  = 5'd3;
    i_wr_data = 32'hA5A5A5A5;
    i_rs_sel  = 5'd3;
    i_rt_sel  = 5'd7;
    #1;
`ifdef REG_BYPASS_EN
    check_value("fwd_rs3", o_rs_data, 32'hA5A5A5A5);
`else
    check_value("fwd_rs3", o_rs_data, 32'h0);
`endif
    check_value("fwd_rt7", o_rt_data, 32'h12345678);
    tick();
    i_wr_en = 1'b0;
    #1;
    check_value("after_wr_rs3", o_rs_data, 32'hA5A5A5A5);

    // Full dump with ready held high
    for (int i = 0; i < DEPTH; i++) write_reg(ADDR_W'(i), 32'(i) * 32'h11);
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    words = 0;
    first_valid = 0;
    done_cnt = 0;
    done_cycle = 0;
    for (int n = 1; n <= 100; n++) begin
      if (o_dump_valid) begin
        if (words == 0) first_valid = n;
        check_value("dump_addr", {27'b0, o_dump_addr}, 32'(words));
        check_value("dump_data", o_dump_data, 32'(words) * 32'h11);
        words++;
      end
      if (o_dump_done) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = n + 1;
      end
      tick();
    end
    check_value("dump_words", 32'(words), 32'(DEPTH));
    check_value("dump_first_valid", 32'(first_valid), 32'd2);
    check_value("dump_done_count", 32'(done_cnt), 32'd1);
    check_value("dump_done_cycle", 32'(done_cycle), 32'(2 * DEPTH + 2));

    // Backpressure on word 4 while register 4 is overwritten
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    wait_for_word(5'd4, found);
    check_value("bp_reach_word4", {31'b0, found}, 32'h1);
    i_dump_ready = 1'b0;
    i_wr_en   = 1'b1;
    i_rd_sel  = 5'd4;
    i_wr_data = 32'h0000CAFE;
    for (int k = 0; k < 5; k++) begin
      tick();
      i_wr_en = 1'b0;
      check_value("bp_valid", {31'b0, o_dump_valid}, 32'h1);
      check_value("bp_data", o_dump_data, 32'h44);
      check_value("bp_addr", {27'b0, o_dump_addr}, 32'h4);
    end
    i_rs_sel = 5'd4;
    #1;
    check_value("bp_rd4", o_rs_data, 32'h0000CAFE);
    i_dump_ready = 1'b1;
    tick();
    check_value("bp_load_valid", {31'b0, o_dump_valid}, 32'h0);
    tick();
    check_value("bp_next_addr", {27'b0, o_dump_addr}, 32'h5);
    check_value("bp_next_data", o_dump_data, 32'h55);
    wait_for_done(found);
    check_value("bp_done", {31'b0, found}, 32'h1);
    tick();

    // Reset during a dump aborts it
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    wait_for_word(5'd10, found);
    check_value("rst_reach_word10", {31'b0, found}, 32'h1);
    check_value("rst_word10_data", o_dump_data, 32'hAA);
    i_rst_n = 1'b0;
    #1;
    check_value("abort_valid", {31'b0, o_dump_valid}, 32'h0);
    check_value("abort_busy", {31'b0, o_dump_busy}, 32'h0);
    check_value("abort_done", {31'b0, o_dump_done}, 32'h0);
    tick();
    i_rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_dump_done || o_dump_valid || o_dump_busy) stray++;
      tick();
    end
    check_value("abort_quiet", 32'(stray), 32'h0);
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    check_value("restart_busy", {31'b0, o_dump_busy}, 32'h1);
    check_value("restart_load_valid", {31'b0, o_dump_valid}, 32'h0);
    tick();
    check_value("restart_valid", {31'b0, o_dump_valid}, 32'h1);
    check_value("restart_addr0", {27'b0, o_dump_addr}, 32'h0);
    check_value("restart_data0", o_dump_data, 32'h0);
    tick();
    tick();
    check_value("restart_addr1", {27'b0, o_dump_addr}, 32'h1);
    check_value("restart_data1", o_dump_data, 32'h0);
    wait_for_done(found);
    check_value("restart_done", {31'b0, found}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
